// File: rtl/aes_key_loader.sv
// AES key loader: assembles 4/6/8 key words (most significant word first) into a
// 256-bit key, holds it for the round-key generator and tracks the round index.
module aes_key_loader #(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   cfg_mode,
    input  logic         word_valid,
    input  logic [31:0]  word_data,
    output logic         word_ready,
    input  logic         clear,
    input  logic         key_release,
    input  logic         round_step,
    output logic [255:0] key_in,
    output logic [1:0]   mode,
    output logic         key_valid,
    output logic [3:0]   round,
    output logic         round_last,
    output logic         busy,
    output logic         err_mode,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic [255:0]   r_key;
    logic [1:0]     r_mode;
    logic [3:0]     r_count;
    logic [3:0]     r_round;
    logic           r_ready;
    logic           r_key_valid;
    logic           r_round_last;
    logic           r_busy;
    logic           r_err;

    state_t         w_state_nx;
    logic [255:0]   w_key_nx;
    logic [1:0]     w_mode_nx;
    logic [3:0]     w_count_nx;
    logic [3:0]     w_round_nx;
    logic           w_err_nx;
    logic           w_xfer;
    logic [7:0]     w_base;

    function automatic logic [3:0] f_words(input logic [1:0] m);
        case (m)
            2'b00:   f_words = 4'd4;
            2'b01:   f_words = 4'd6;
            default: f_words = 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] f_nr(input logic [1:0] m);
        case (m)
            2'b00:   f_nr = 4'd10;
            2'b01:   f_nr = 4'd12;
            default: f_nr = 4'd14;
        endcase
    endfunction

    // Handshake: a key word moves on a rising edge where word_valid and word_ready
    // are both high; word_ready drops combinationally while clear is asserted.
    assign word_ready = r_ready & ~clear;
    assign w_xfer     = word_valid & word_ready;
    assign w_base     = 8'd255 - {r_count[2:0], 5'b0_0000};

    always_comb begin
        w_state_nx = r_state;
        w_key_nx   = r_key;
        w_mode_nx  = r_mode;
        w_count_nx = r_count;
        w_round_nx = r_round;
        w_err_nx   = 1'b0;
        if (clear) begin
            w_state_nx = S_IDLE;
            w_mode_nx  = 2'b00;
            w_count_nx = 4'd0;
            w_round_nx = 4'd0;
            if (ZEROIZE) w_key_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (cfg_mode == 2'b11) begin
                            w_err_nx = 1'b1;
                        end else begin
                            // Clearing the tail keeps short keys zero-padded even when retained.
                            w_key_nx   = {word_data, 224'd0};
                            w_mode_nx  = cfg_mode;
                            w_count_nx = 4'd1;
                            w_state_nx = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        w_key_nx[w_base -: 32] = word_data;
                        w_count_nx = r_count + 4'd1;
                        if (r_count == f_words(r_mode) - 4'd1) begin
                            w_state_nx = S_HOLD;
                            w_count_nx = 4'd0;
                            w_round_nx = 4'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (key_release) begin
                        w_state_nx = S_IDLE;
                        w_round_nx = 4'd0;
                        if (ZEROIZE) w_key_nx = '0;
                    end else if (round_step && (r_round != f_nr(r_mode))) begin
                        w_round_nx = r_round + 4'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_count_nx = 4'd0;
                    w_round_nx = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_mode       <= 2'b00;
            r_count      <= 4'd0;
            r_round      <= 4'd0;
            r_ready      <= 1'b0;
            r_key_valid  <= 1'b0;
            r_round_last <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_key        <= w_key_nx;
            r_mode       <= w_mode_nx;
            r_count      <= w_count_nx;
            r_round      <= w_round_nx;
            r_ready      <= (w_state_nx != S_HOLD);
            r_key_valid  <= (w_state_nx == S_HOLD);
            r_round_last <= (w_state_nx == S_HOLD) && (w_round_nx == f_nr(w_mode_nx));
            r_busy       <= (w_state_nx != S_IDLE);
            r_err        <= w_err_nx;
        end
    end

    assign key_in     = r_key;
    assign mode       = r_mode;
    assign key_valid  = r_key_valid;
    assign round      = r_round;
    assign round_last = r_round_last;
    assign busy       = r_busy;
    assign err_mode   = r_err;
    assign dbg_state  = r_state;

endmodule
